srs_hop_gen: RTL and testbench

//  Generates 3GPP 38.211 §6.4.1.4.2 SRS group/sequence-hopping values (u, v) for every SRS symbol of one request.

---
 rtl/srs_hop_pkg.sv | 72 +++++++
 rtl/gold_par_gen.sv | 66 ++++++
 rtl/srs_hop_gen.sv | 228 ++++++++++++++++++++++
 tb/tb_srs_hop_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/srs_hop_pkg.sv
// rtl/srs_hop_pkg.sv - shared types, constants and helpers for the SRS hopping generator
// Build option: SRS_HOP_FF_EN adds the Gold fast-forward constants X1_FF / X2_FF_MATRIX.
package srs_hop_pkg;

   typedef enum logic [1:0] {
      HOP_NONE  = 2'b00,
      HOP_GROUP = 2'b01,
      HOP_SEQ   = 2'b10,
      HOP_RSVD  = 2'b11
   } hop_mode_e;

   typedef enum logic [1:0] {
      SYMB_1    = 2'b00,
      SYMB_2    = 2'b01,
      SYMB_RSVD = 2'b10,
      SYMB_4    = 2'b11
   } symb_num_e;

   localparam int         SRS_NC            = 1600;
   localparam logic [3:0] SYMB_PER_SLOT_NCP = 4'd14;
   localparam logic [3:0] SYMB_PER_SLOT_ECP = 4'd12;

   function automatic logic [5:0] div30(input logic [9:0] n);
      return 6'(n / 10'd30);
   endfunction

   function automatic logic [4:0] mod30(input logic [9:0] n);
      return 5'(n % 10'd30);
   endfunction

   // f_gh (<=255) plus residue (<=29) stays below 285, so four conditional
   // subtractions of descending multiples of 30 always land in 0..29.
   function automatic logic [4:0] mod30_reduce(input logic [8:0] s);
      logic [8:0] r;
      r = s;
      if (r >= 9'd240) r = r - 9'd240;
      if (r >= 9'd120) r = r - 9'd120;
      if (r >= 9'd60)  r = r - 9'd60;
      if (r >= 9'd30)  r = r - 9'd30;
      return r[4:0];
   endfunction

`ifdef SRS_HOP_FF_EN
   // Bit-serial advance used only at elaboration; the split loop keeps each
   // loop's trip count small for constant evaluation.
   function automatic logic [30:0] gold_adv(input logic [30:0] s, input logic is_x2, input int n);
      logic [30:0] r;
      logic        fb;
      r = s;
      for (int a = 0; a < n; a += 40) begin
         for (int b = 0; b < 40; b++) begin
            if (a + b < n) begin
               fb = is_x2 ? (r[0] ^ r[1] ^ r[2] ^ r[3]) : (r[0] ^ r[3]);
               r  = {fb, r[30:1]};
            end
         end
      end
      return r;
   endfunction

   // Column j is the NC-advanced image of unit vector j; x2 is linear in c_init.
   function automatic logic [30:0][30:0] gen_x2_ff_matrix();
      logic [30:0][30:0] m;
      for (int j = 0; j < 31; j++) m[j] = gold_adv(31'(1) << j, 1'b1, SRS_NC);
      return m;
   endfunction

   localparam logic [30:0]        X1_FF        = gold_adv(31'd1, 1'b0, SRS_NC);
   localparam logic [30:0][30:0]  X2_FF_MATRIX = gen_x2_ff_matrix();
`endif

endpackage

// File: rtl/gold_par_gen.sv
// rtl/gold_par_gen.sv - PAR_W-bit-per-clock Gold sequence engine with load and advance
// Build option: SRS_HOP_FF_EN loads the state already advanced past the NC discard.
module gold_par_gen
   import srs_hop_pkg::*;
#(
   parameter int PAR_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             adv,
   input  logic [30:0]      c_init,
   output logic [PAR_W-1:0] c_win
);

   logic [30:0] x1_q;
   logic [30:0] x2_q;
   logic [30:0] x1_step;
   logic [30:0] x2_step;
   logic [30:0] x1_init;
   logic [30:0] x2_init;

   // Bit i holds x(n+i). Bits shifted in from beyond the register come from a
   // single XOR of current bits, which holds while PAR_W <= 28.
   for (genvar i = 0; i < 31; i++) begin : g_step
      if (i + PAR_W < 31) begin : g_shift
         assign x1_step[i] = x1_q[i+PAR_W];
         assign x2_step[i] = x2_q[i+PAR_W];
      end else begin : g_fb
         assign x1_step[i] = x1_q[i+PAR_W-28] ^ x1_q[i+PAR_W-31];
         assign x2_step[i] = x2_q[i+PAR_W-28] ^ x2_q[i+PAR_W-29]
                           ^ x2_q[i+PAR_W-30] ^ x2_q[i+PAR_W-31];
      end
   end

`ifdef SRS_HOP_FF_EN
   assign x1_init = X1_FF;
   // GF(2) matrix-vector product: XOR of the columns selected by c_init.
   always_comb begin
      x2_init = '0;
      for (int j = 0; j < 31; j++) begin
         if (c_init[j]) x2_init = x2_init ^ X2_FF_MATRIX[j];
      end
   end
`else
   assign x1_init = 31'd1;
   assign x2_init = c_init;
`endif

   // LFSR state: load has priority, otherwise advance by PAR_W when asked.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x1_q <= '0;
         x2_q <= '0;
      end else if (load) begin
         x1_q <= x1_init;
         x2_q <= x2_init;
      end else if (adv) begin
         x1_q <= x1_step;
         x2_q <= x2_step;
      end
   end

   assign c_win = x1_q[PAR_W-1:0] ^ x2_q[PAR_W-1:0];

endmodule

// File: rtl/srs_hop_gen.sv
// rtl/srs_hop_gen.sv - SRS group/sequence hopping (u,v) generator, one beat per SRS symbol
// Build option: SRS_HOP_FF_EN starts the engine past the NC discard (constants assume NC == SRS_NC).
module srs_hop_gen
   import srs_hop_pkg::*;
#(
   parameter int PAR_W   = 16,
   parameter int NSLOT_W = 8,
   parameter int NC      = SRS_NC
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               busy,
   input  logic [NSLOT_W-1:0] n_slot,
   input  logic               ecp,
   input  logic [1:0]         symb_num,
   input  logic [3:0]         start_symb,
   input  logic [1:0]         hop_mode,
   input  logic [9:0]         n_id,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [4:0]         out_u,
   output logic               out_v,
   output logic [1:0]         out_idx,
   output logic               out_last,
   output logic               done,
   output logic               err
);

   localparam int K_W   = NSLOT_W + 4;
   localparam int POS_W = $clog2(NC + 8 * (2 ** K_W) + 64);

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LOAD, S_SEEK, S_EMIT, S_DONE} state_e;

   state_e             state_q, state_d;
   logic [NSLOT_W-1:0] n_slot_q;
   logic               ecp_q;
   symb_num_e          symb_num_q;
   logic [3:0]         start_symb_q;
   hop_mode_e          hop_q;
   logic [9:0]         n_id_q;
   logic               err_q;
   logic [POS_W-1:0]   pos_q;
   logic [POS_W-1:0]   need_q;
   logic [3:0]         got_q;
   logic [7:0]         gath_q;
   logic [1:0]         idx_q;
   logic               out_valid_q, out_v_q, out_last_q;
   logic [4:0]         out_u_q;
   logic [1:0]         out_idx_q;

   logic [2:0]         nsym;
   logic [3:0]         nsps;
   logic               req_bad, is_group, eng_load, eng_adv, accept;
   logic [4:0]         nid_mod;
   logic [30:0]        c_init;
   logic [K_W-1:0]     k0;
   logic [POS_W-1:0]   first_bit, diff;
   logic               in_win, complete, win_end, gathering;
   logic [4:0]         offs;
   logic [5:0]         avail;
   logic [3:0]         want, take, take_eff;
   logic [7:0]         sh8, mask8, gath_next;
   logic [1:0]         last_idx;
   logic [PAR_W-1:0]   c_win;

   gold_par_gen #(.PAR_W(PAR_W)) u_gold (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (eng_load),
      .adv    (eng_adv),
      .c_init (c_init),
      .c_win  (c_win)
   );

   // Number of SRS symbols in the latched request.
   always_comb begin
      nsym = 3'd4;
      case (symb_num_q)
         SYMB_1:  nsym = 3'd1;
         SYMB_2:  nsym = 3'd2;
         default: nsym = 3'd4;
      endcase
   end

   assign nsps      = ecp_q ? SYMB_PER_SLOT_ECP : SYMB_PER_SLOT_NCP;
   assign req_bad   = (symb_num_q == SYMB_RSVD) || (hop_q == HOP_RSVD) ||
                      (({1'b0, start_symb_q} + {2'b0, nsym}) > {1'b0, nsps});
   assign is_group  = (hop_q == HOP_GROUP);
   assign nid_mod   = mod30(n_id_q);
   assign c_init    = is_group ? 31'(div30(n_id_q)) : 31'(n_id_q);
   assign k0        = K_W'(n_slot_q) * K_W'(nsps) + K_W'(start_symb_q);
   assign first_bit = is_group ? (POS_W'(k0) << 3) : POS_W'(k0);
   assign last_idx  = 2'(nsym - 3'd1);
   assign accept    = out_valid_q && out_ready;

   // Gather: take up to the bits still wanted for this beat from the current
   // window; a group beat may straddle two windows and then takes two clocks.
   assign diff      = need_q - pos_q;
   assign in_win    = diff < POS_W'(PAR_W);
   assign offs      = diff[4:0];
   assign avail     = 6'(PAR_W) - {1'b0, offs};
   assign want      = (is_group ? 4'd8 : 4'd1) - got_q;
   assign take      = ({2'b0, want} > avail) ? avail[3:0] : want;
   assign take_eff  = in_win ? take : 4'd0;
   assign sh8       = 8'(c_win >> offs);
   assign mask8     = 8'((9'd1 << take_eff) - 9'd1);
   assign gath_next = gath_q | ((sh8 & mask8) << got_q);
   assign complete  = in_win && ((got_q + take) == (is_group ? 4'd8 : 4'd1));
   assign win_end   = ({1'b0, offs} + {2'b0, take_eff}) == 6'(PAR_W);
   assign gathering = (state_q == S_EMIT) && !out_valid_q && (hop_q != HOP_NONE);
   assign eng_adv   = ((state_q == S_SEEK) && !in_win) || (gathering && (!in_win || win_end));

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_CHECK;
         S_CHECK: state_d = req_bad ? S_DONE : S_LOAD;
         S_LOAD:  state_d = (hop_q == HOP_NONE) ? S_EMIT : S_SEEK;
         S_SEEK:  if (in_win) state_d = S_EMIT;
         S_EMIT:  if (accept && out_last_q) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs decoded from state.
   always_comb begin
      busy     = (state_q != S_IDLE);
      done     = (state_q == S_DONE);
      err      = (state_q == S_DONE) && err_q;
      eng_load = (state_q == S_LOAD);
   end

   // Request latch, seek/gather bookkeeping and the output beat registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_slot_q     <= '0;
         ecp_q        <= 1'b0;
         symb_num_q   <= SYMB_1;
         start_symb_q <= '0;
         hop_q        <= HOP_NONE;
         n_id_q       <= '0;
         err_q        <= 1'b0;
         pos_q        <= '0;
         need_q       <= '0;
         got_q        <= '0;
         gath_q       <= '0;
         idx_q        <= '0;
         out_valid_q  <= 1'b0;
         out_u_q      <= '0;
         out_v_q      <= 1'b0;
         out_idx_q    <= '0;
         out_last_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  n_slot_q     <= n_slot;
                  ecp_q        <= ecp;
                  symb_num_q   <= symb_num_e'(symb_num);
                  start_symb_q <= start_symb;
                  hop_q        <= hop_mode_e'(hop_mode);
                  n_id_q       <= n_id;
                  err_q        <= 1'b0;
               end
            end
            S_CHECK: err_q <= req_bad;
            S_LOAD: begin
`ifdef SRS_HOP_FF_EN
               pos_q <= POS_W'(NC);
`else
               pos_q <= '0;
`endif
               need_q <= POS_W'(NC) + first_bit;
               got_q  <= '0;
               gath_q <= '0;
               idx_q  <= '0;
            end
            S_SEEK: if (eng_adv) pos_q <= pos_q + POS_W'(PAR_W);
            S_EMIT: begin
               if (out_valid_q) begin
                  if (out_ready) begin
                     out_valid_q <= 1'b0;
                     idx_q       <= idx_q + 2'd1;
                  end
               end else if (hop_q == HOP_NONE) begin
                  out_valid_q <= 1'b1;
                  out_u_q     <= nid_mod;
                  out_v_q     <= 1'b0;
                  out_idx_q   <= idx_q;
                  out_last_q  <= (idx_q == last_idx);
               end else begin
                  if (eng_adv) pos_q <= pos_q + POS_W'(PAR_W);
                  need_q <= need_q + POS_W'(take_eff);
                  if (complete) begin
                     out_valid_q <= 1'b1;
                     out_u_q     <= is_group ? mod30_reduce(9'(gath_next) + 9'(nid_mod)) : nid_mod;
                     out_v_q     <= is_group ? 1'b0 : gath_next[0];
                     out_idx_q   <= idx_q;
                     out_last_q  <= (idx_q == last_idx);
                     got_q       <= '0;
                     gath_q      <= '0;
                  end else begin
                     got_q  <= got_q + take_eff;
                     gath_q <= gath_next;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_u     = out_u_q;
   assign out_v     = out_v_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_srs_hop_gen.sv
// tb/tb_srs_hop_gen.sv - scoreboard bench for srs_hop_gen (works with or without SRS_HOP_FF_EN)
module tb_srs_hop_gen;

   localparam int NC = 1600;

   typedef struct packed {
      logic [4:0] u;
      logic       v;
      logic [1:0] idx;
      logic       last;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       busy;
   logic [7:0] n_slot = '0;
   logic       ecp = 1'b0;
   logic [1:0] symb_num = '0;
   logic [3:0] start_symb = '0;
   logic [1:0] hop_mode = '0;
   logic [9:0] n_id = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [4:0] out_u;
   logic       out_v;
   logic [1:0] out_idx;
   logic       out_last;
   logic       done;
   logic       err;

   int    n_pass = 0;
   int    n_tot  = 0;
   int    done_cnt = 0;
   bit    rand_ready = 1'b0;
   beat_t exp_q[$];
   bit    exp_err_q[$];
   bit    gx1 [40000];
   bit    gx2 [40000];

   srs_hop_gen #(.PAR_W(16), .NSLOT_W(8), .NC(NC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .busy       (busy),
      .n_slot     (n_slot),
      .ecp        (ecp),
      .symb_num   (symb_num),
      .start_symb (start_symb),
      .hop_mode   (hop_mode),
      .n_id       (n_id),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_u      (out_u),
      .out_v      (out_v),
      .out_idx    (out_idx),
      .out_last   (out_last),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Reference Gold sequence built directly from the recurrences.
   function automatic void gold_fill(input int cinit, input int len);
      for (int i = 0; i < 31; i++) begin
         gx1[i] = (i == 0);
         gx2[i] = cinit[i];
      end
      for (int n = 0; n + 31 < NC + len; n++) begin
         gx1[n+31] = gx1[n+3] ^ gx1[n];
         gx2[n+31] = gx2[n+3] ^ gx2[n+2] ^ gx2[n+1] ^ gx2[n];
      end
   endfunction

   function automatic bit gold_c(input int n);
      return gx1[n+NC] ^ gx2[n+NC];
   endfunction

   task automatic run_req(input int hm, input int nid, input int slot, input int e,
                          input int sn, input int l0);
      int    nsym, nsps, cinit, k, fgh, d0, cyc;
      bit    bad;
      beat_t b;
      nsym = (sn == 0) ? 1 : (sn == 1) ? 2 : 4;
      nsps = (e != 0) ? 12 : 14;
      bad  = (sn == 2) || (hm == 3) || (l0 + nsym > nsps);
      if (!bad) begin
         cinit = (hm == 1) ? nid / 30 : nid;
         if (hm != 0) gold_fill(cinit, 8 * (slot * nsps + l0 + nsym) + 8);
         for (int l = 0; l < nsym; l++) begin
            k   = slot * nsps + l0 + l;
            b.u = 5'(nid % 30);
            b.v = 1'b0;
            if (hm == 1) begin
               fgh = 0;
               for (int m = 0; m < 8; m++) fgh += int'(gold_c(8 * k + m)) << m;
               b.u = 5'((fgh + nid % 30) % 30);
            end else if (hm == 2) begin
               b.v = gold_c(k);
            end
            b.idx  = 2'(l);
            b.last = (l == nsym - 1);
            exp_q.push_back(b);
         end
      end
      exp_err_q.push_back(bad);
      @(posedge clk); #1;
      hop_mode = 2'(hm); n_id = 10'(nid); n_slot = 8'(slot); ecp = e[0];
      symb_num = 2'(sn); start_symb = 4'(l0); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_id = ~n_id; n_slot = ~n_slot; ecp = ~ecp; start_symb = ~start_symb;
      hop_mode = ~hop_mode; symb_num = ~symb_num;
      d0 = done_cnt; cyc = 0;
      while (done_cnt == d0 && cyc < 5000) begin
         @(posedge clk);
         cyc++;
      end
      chk("done_seen", int'(done_cnt != d0), 1);
      chk("beats_left", exp_q.size(), 0);
      exp_q.delete();
      exp_err_q.delete();
   endtask

   // Ready driver: always ready, or high about 30% of cycles.
   initial forever begin
      @(posedge clk); #1;
      out_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
   end

   // Monitor: beat scoreboard, stall stability and done/err pulses.
   initial begin
      bit    stall_prev;
      beat_t held, act;
      stall_prev = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            act = {out_u, out_v, out_idx, out_last};
            if (stall_prev) chk("stall_hold", {out_valid, act}, {1'b1, held});
            if (out_valid && out_ready) begin
               chk("beat_expected", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) chk("beat", act, exp_q.pop_front());
            end
            stall_prev = out_valid && !out_ready;
            held = act;
            if (done) begin
               chk("done_expected", int'(exp_err_q.size() > 0), 1);
               if (exp_err_q.size() > 0) chk("err_flag", err, exp_err_q.pop_front());
               done_cnt++;
            end else if (err) begin
               chk("err_without_done", 1, 0);
            end
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_tot=%0d", n_pass, n_tot);
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", {busy, out_valid, out_u, out_v, out_idx, out_last, done, err}, 0);
      rst_n = 1'b1;

      run_req(0, 100, 0, 0, 1, 0);
      run_req(1, 45, 3, 0, 3, 8);
      run_req(2, 1023, 159, 0, 3, 10);
      run_req(1, 517, 7, 1, 3, 8);
      run_req(2, 7, 0, 0, 0, 13);
      run_req(1, 45, 3, 0, 3, 12);
      run_req(2, 45, 3, 0, 2, 0);
      run_req(3, 45, 3, 0, 0, 0);
      run_req(1, 45, 3, 1, 3, 9);

      rand_ready = 1'b1;
      run_req(1, 45, 3, 0, 3, 8);
      run_req(2, 1023, 159, 0, 3, 10);
      run_req(0, 100, 0, 0, 1, 0);
      rand_ready = 1'b0;

      @(posedge clk); #1;
      hop_mode = 2'd2; n_id = 10'd1023; n_slot = 8'd159; ecp = 1'b0;
      symb_num = 2'd3; start_symb = 4'd10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("busy_in_seek", busy, 1);
      rst_n = 1'b0;
      #2;
      chk("abort_outs", {busy, out_valid, out_u, out_v, out_idx, out_last, done, err}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_req(0, 100, 0, 0, 1, 0);
      run_req(2, 1023, 159, 0, 3, 10);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
